cpu_datapath: RTL and testbench

Register-level datapath driven by the sequence controller. It contains the program counter, instruction register, accumulator and ALU, and drives the memory address and write data. It returns `opcode` and `zero` to the controller, which decodes them into the next cycle's strobes. The datapath performs no decoding of its own beyond ALU operation selection.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cpu_datapath_alu.sv | 25 ++
 rtl/cpu_datapath.sv | 89 ++++++++
 tb/tb_cpu_datapath.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode encoding and field widths.
package cpu_pkg;

    localparam int unsigned OP_W = 3;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_HLT = 3'b000;
    localparam opcode_t OP_SKZ = 3'b001;
    localparam opcode_t OP_ADD = 3'b010;
    localparam opcode_t OP_AND = 3'b011;
    localparam opcode_t OP_XOR = 3'b100;
    localparam opcode_t OP_LDA = 3'b101;
    localparam opcode_t OP_STO = 3'b110;
    localparam opcode_t OP_JMP = 3'b111;

endpackage : cpu_pkg

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU: combines the accumulator with memory read data per opcode.
module dp_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  opcode_t           opcode_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] result_o
);

    // Opcodes without an ALU function pass the accumulator through.
    always_comb begin
        result_o = acc_i;
        case (opcode_i)
            OP_ADD:  result_o = acc_i + data_i;
            OP_AND:  result_o = acc_i & data_i;
            OP_XOR:  result_o = acc_i ^ data_i;
            OP_LDA:  result_o = data_i;
            default: result_o = acc_i;
        endcase
    end

endmodule : dp_alu

// File: rtl/cpu_datapath.sv
// Register-level datapath: PC, IR, accumulator and halt status, steered by
// controller strobes; exposes opcode and zero back to the controller.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_ir,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic              load_ac,
    input  logic              halt,
    input  logic              sel,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [OP_W-1:0]   opcode,
    output logic              zero,
    output logic              halted
);

    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              halted_q, halted_d;

    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] alu_result;

    assign operand = ir_q[ADDR_W-1:0];
    assign opcode  = ir_q[DATA_W-1 -: OP_W];

    // ALU reads the registered IR, so a same-cycle IR load does not affect it.
    dp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode_i (opcode_t'(opcode)),
        .acc_i    (acc_q),
        .data_i   (mem_rdata),
        .result_o (alu_result)
    );

    // Next-state: once halted, every register holds until reset.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (load_pc) begin
                pc_d = operand;
            end else if (inc_pc) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            if (load_ir) begin
                ir_d = mem_rdata;
            end
            if (load_ac) begin
                acc_d = alu_result;
            end
            if (halt) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            ir_q     <= '0;
            acc_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            acc_q    <= acc_d;
            halted_q <= halted_d;
        end
    end

    assign mem_addr  = sel ? pc_q : operand;
    assign mem_wdata = acc_q;
    assign zero      = (acc_q == '0);
    assign halted    = halted_q;

endmodule : cpu_datapath

// File: tb/tb_cpu_datapath.sv
// Directed, table-driven bench for cpu_datapath with hand-computed expectations.
module tb_cpu_datapath;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    // Strobe bundle order: {load_ir, inc_pc, load_pc, load_ac, halt}
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_IR   = 5'b10000;
    localparam logic [4:0] S_INC  = 5'b01000;
    localparam logic [4:0] S_LPC  = 5'b00100;
    localparam logic [4:0] S_LAC  = 5'b00010;
    localparam logic [4:0] S_HLT  = 5'b00001;

    typedef struct {
        logic [4:0]        strb;
        logic              sel;
        logic [DATA_W-1:0] rdata;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [2:0]        op;
        logic              z;
        logic              h;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_ir, inc_pc, load_pc, load_ac, halt, sel;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        opcode;
    logic              zero;
    logic              halted;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cpu_datapath #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_ir   (load_ir),
        .inc_pc    (inc_pc),
        .load_pc   (load_pc),
        .load_ac   (load_ac),
        .halt      (halt),
        .sel       (sel),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .opcode    (opcode),
        .zero      (zero),
        .halted    (halted)
    );

    function automatic vec_t mk(input logic [4:0] strb, input logic s, input logic [7:0] rd,
                                input logic [4:0] a, input logic [7:0] w, input logic [2:0] op,
                                input logic z, input logic h);
        vec_t v;
        v.strb = strb; v.sel = s; v.rdata = rd;
        v.addr = a; v.wdata = w; v.op = op; v.z = z; v.h = h;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] strb, input logic s, input logic [7:0] rd);
        {load_ir, inc_pc, load_pc, load_ac, halt} = strb;
        sel       = s;
        mem_rdata = rd;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        drive(5'($urandom), 1'($urandom), 8'($urandom));
        @(posedge clk);
        @(negedge clk);
        drive(5'($urandom), 1'($urandom), 8'($urandom));
        @(posedge clk);
        #1;
        sel = 1'b1;
        #1;
        check({tag, " addr_sel1"}, 32'(mem_addr), 32'h0);
        sel = 1'b0;
        #1;
        check({tag, " addr_sel0"}, 32'(mem_addr), 32'h0);
        check({tag, " acc"},       32'(mem_wdata), 32'h0);
        check({tag, " opcode"},    32'(opcode), 32'h0);
        check({tag, " zero"},      32'(zero), 32'h1);
        check({tag, " halted"},    32'(halted), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(S_NONE, 1'b1, 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        drive(S_NONE, 1'b1, 8'h00);

        // Fetch/ALU sequence, jump priority, PC wrap, XOR-to-zero/SKZ, halt.
        vecs.push_back(mk(S_IR,              1, 8'hA0, 5'h00, 8'h00, 3'd5, 1, 0));
        vecs.push_back(mk(S_LAC,             0, 8'hFD, 5'h00, 8'hFD, 3'd5, 0, 0));
        vecs.push_back(mk(S_IR | S_INC,      1, 8'h4A, 5'h01, 8'hFD, 3'd2, 0, 0));
        vecs.push_back(mk(S_LAC,             0, 8'h07, 5'h0A, 8'h04, 3'd2, 0, 0));
        vecs.push_back(mk(S_IR | S_LAC,      0, 8'h63, 5'h03, 8'h67, 3'd3, 0, 0));
        vecs.push_back(mk(S_LAC,             0, 8'h0F, 5'h03, 8'h07, 3'd3, 0, 0));
        vecs.push_back(mk(S_IR,              1, 8'hF3, 5'h01, 8'h07, 3'd7, 0, 0));
        vecs.push_back(mk(S_INC,             1, 8'h00, 5'h02, 8'h07, 3'd7, 0, 0));
        vecs.push_back(mk(S_INC,             1, 8'h00, 5'h03, 8'h07, 3'd7, 0, 0));
        vecs.push_back(mk(S_INC,             1, 8'h00, 5'h04, 8'h07, 3'd7, 0, 0));
        vecs.push_back(mk(S_INC,             1, 8'h00, 5'h05, 8'h07, 3'd7, 0, 0));
        vecs.push_back(mk(S_LPC | S_INC,     1, 8'h00, 5'h13, 8'h07, 3'd7, 0, 0));
        vecs.push_back(mk(S_LAC,             1, 8'hAA, 5'h13, 8'h07, 3'd7, 0, 0));
        vecs.push_back(mk(S_IR,              0, 8'hFF, 5'h1F, 8'h07, 3'd7, 0, 0));
        vecs.push_back(mk(S_LPC,             1, 8'h00, 5'h1F, 8'h07, 3'd7, 0, 0));
        vecs.push_back(mk(S_INC,             1, 8'h00, 5'h00, 8'h07, 3'd7, 0, 0));
        vecs.push_back(mk(S_IR,              1, 8'hA2, 5'h00, 8'h07, 3'd5, 0, 0));
        vecs.push_back(mk(S_LAC,             0, 8'h55, 5'h02, 8'h55, 3'd5, 0, 0));
        vecs.push_back(mk(S_IR,              0, 8'h84, 5'h04, 8'h55, 3'd4, 0, 0));
        vecs.push_back(mk(S_LAC,             1, 8'h55, 5'h00, 8'h00, 3'd4, 1, 0));
        vecs.push_back(mk(S_INC,             1, 8'h00, 5'h01, 8'h00, 3'd4, 1, 0));
        vecs.push_back(mk(S_IR,              1, 8'h00, 5'h01, 8'h00, 3'd0, 1, 0));
        vecs.push_back(mk(S_LAC,             1, 8'h33, 5'h01, 8'h00, 3'd0, 1, 0));
        vecs.push_back(mk(S_IR,              1, 8'hE9, 5'h01, 8'h00, 3'd7, 1, 0));
        vecs.push_back(mk(S_LPC,             1, 8'h00, 5'h09, 8'h00, 3'd7, 1, 0));
        vecs.push_back(mk(S_HLT | S_INC,     1, 8'h00, 5'h0A, 8'h00, 3'd7, 1, 1));
        vecs.push_back(mk(5'b11110,          1, 8'h12, 5'h0A, 8'h00, 3'd7, 1, 1));
        vecs.push_back(mk(5'b11110,          0, 8'h12, 5'h09, 8'h00, 3'd7, 1, 1));
        vecs.push_back(mk(S_LAC | S_LPC,     1, 8'h12, 5'h0A, 8'h00, 3'd7, 1, 1));
        vecs.push_back(mk(S_IR | S_INC,      1, 8'h45, 5'h0A, 8'h00, 3'd7, 1, 1));
        vecs.push_back(mk(S_LAC | S_HLT,     1, 8'h12, 5'h0A, 8'h00, 3'd7, 1, 1));

        do_reset("reset0");

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].strb, vecs[i].sel, vecs[i].rdata);
            @(posedge clk);
            #1;
            check($sformatf("v%0d addr", i),   32'(mem_addr),  32'(vecs[i].addr));
            check($sformatf("v%0d wdata", i),  32'(mem_wdata), 32'(vecs[i].wdata));
            check($sformatf("v%0d opcode", i), 32'(opcode),    32'(vecs[i].op));
            check($sformatf("v%0d zero", i),   32'(zero),      32'(vecs[i].z));
            check($sformatf("v%0d halted", i), 32'(halted),    32'(vecs[i].h));
        end

        // Reset must override the sticky halted state.
        do_reset("reset_after_halt");

        // Reset mid-instruction discards partially loaded state.
        @(negedge clk);
        drive(S_IR | S_INC, 1'b1, 8'hBC);
        @(posedge clk);
        #1;
        check("mid addr", 32'(mem_addr), 32'h01);
        check("mid opcode", 32'(opcode), 32'h5);
        do_reset("reset_mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cpu_datapath
